// File: rtl/keypad_pkg.sv
// Shared types and the key legend for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [0:0] {SCAN, PRESSED} scan_state_t;

  // KEYMAP[row][col]
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Index of the lowest-numbered low (pressed) row; only meaningful when some row is low.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    casez (r)
      4'b???0: low_row = 2'd0;
      4'b??01: low_row = 2'd1;
      4'b?011: low_row = 2'd2;
      default: low_row = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer; resets to all-ones so idle pulled-up lines read released.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader that locks on the first key seen until it is released.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_pressed,
  output logic       key_strobe
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);

  logic [3:0]    rows_s;
  scan_state_t   state, state_n;
  logic [1:0]    col_idx, col_n;
  logic [1:0]    row_idx, row_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [RW-1:0] rel, rel_n;
  logic [3:0]    code_n;
  logic          pressed_n, strobe_n;

  sync2 #(.W(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  // Column drive follows col_idx, which stays put while a key is locked.
  assign cols = ~(4'b0001 << col_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      row_idx     <= 2'd0;
      dwell       <= '0;
      rel         <= '0;
      key_code    <= 4'h0;
      key_pressed <= 1'b0;
      key_strobe  <= 1'b0;
    end else begin
      state       <= state_n;
      col_idx     <= col_n;
      row_idx     <= row_n;
      dwell       <= dwell_n;
      rel         <= rel_n;
      key_code    <= code_n;
      key_pressed <= pressed_n;
      key_strobe  <= strobe_n;
    end
  end

  always_comb begin
    state_n   = state;
    col_n     = col_idx;
    row_n     = row_idx;
    dwell_n   = dwell;
    rel_n     = rel;
    code_n    = key_code;
    pressed_n = key_pressed;
    strobe_n  = 1'b0;
    unique case (state)
      SCAN: begin
        if (dwell == DW'(SCAN_DIV - 1)) begin
          dwell_n = '0;
          if (rows_s != 4'b1111) begin
            state_n   = PRESSED;
            row_n     = low_row(rows_s);
            code_n    = KEYMAP[low_row(rows_s)][col_idx];
            pressed_n = 1'b1;
            strobe_n  = 1'b1;
            rel_n     = '0;
          end else begin
            col_n = col_idx + 2'd1;
          end
        end else begin
          dwell_n = dwell + DW'(1);
        end
      end
      PRESSED: begin
        // Any low sample on the held row restarts the release window.
        if (!rows_s[row_idx]) begin
          rel_n = '0;
        end else if (rel == RW'(RELEASE_CYCLES - 1)) begin
          state_n   = SCAN;
          pressed_n = 1'b0;
          col_n     = col_idx + 2'd1;
          dwell_n   = '0;
          rel_n     = '0;
        end else begin
          rel_n = rel + RW'(1);
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule
